vga_timing_generator: RTL and testbench

Raster timing source that drives the pixel interface consumed by the image renderer. It produces the current pixel coordinates `X`/`Y` and `display_on`, plus VGA `hsync`/`vsync`/`blank_n` delayed to line up with the renderer's registered RGB output. It also emits line, vertical-blank and frame strobes that the game logic uses as its update tick. It sits between the pixel-rate clock enable and both the renderer and the VGA DAC pins.

---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/sync_delay_line.sv | 47 ++++
 rtl/vga_timing_generator.sv | 157 +++++++++++++++
 tb/tb_vga_timing_generator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe the 640x480@60 mode driven from a 25.175 MHz pixel enable.
package vga_timing_pkg;

  // Width of the X/Y coordinate buses and all raster arithmetic.
  localparam int unsigned COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing, in pixels.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Vertical timing, in lines.
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Both syncs are active-low in this mode.
  localparam logic DEF_SYNC_POL = 1'b0;

  // Renderer output latency that the DAC-side signals have to match.
  localparam int unsigned DEF_PIPE_DELAY = 2;
  localparam int unsigned MAX_PIPE_DELAY = 7;

  // Layout of the bus that travels through the sync delay line.
  localparam int unsigned SYNC_BUS_W = 3;
  localparam int unsigned BIT_HSYNC  = 2;
  localparam int unsigned BIT_VSYNC  = 1;
  localparam int unsigned BIT_BLANK  = 0;

  // Drive level of a sync line given whether it is currently asserted.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  // True when lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Increment a counter that wraps to zero after reaching 'last'.
  function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
    return (v == last) ? '0 : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that realigns the raw sync/blank bits with the
// renderer's registered pixel output. It clocks every cycle regardless of the
// pixel enable, so its latency is measured in clk cycles. A depth of zero is a
// plain wire.
module sync_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset have no work to do without stages.
      logic w_unused;
      assign w_unused = ^{clk, rst, i_rst_val};
      assign o_q      = i_d;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] r_q;
        logic [WIDTH-1:0] w_in;

        if (gi == 0) begin : g_first
          assign w_in = i_d;
        end else begin : g_chain
          assign w_in = g_stage[gi-1].r_q;
        end

        // One stage of delay; reset loads the idle pattern into every stage.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_q <= i_rst_val;
          end else begin
            r_q <= w_in;
          end
        end
      end

      assign o_q = g_stage[DEPTH-1].r_q;
    end
  endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing source: pixel coordinates and display_on for the renderer,
// delayed hsync/vsync/blank_n for the DAC, and line/vblank/frame strobes that
// the game logic uses as its update tick.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        SYNC_POL   = DEF_SYNC_POL,
  parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic               line_tick,
  output logic               vblank_tick,
  output logic               frame_tick
);

  // Raster geometry, all in 16-bit unsigned coordinate space.
  localparam coord_t H_TOTAL  = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam coord_t V_TOTAL  = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam coord_t H_LAST   = H_TOTAL - coord_t'(1);
  localparam coord_t V_LAST   = V_TOTAL - coord_t'(1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // Depths beyond the supported range are clamped rather than silently
  // producing an oversized shift register.
  localparam int unsigned DLY_DEPTH = (PIPE_DELAY > MAX_PIPE_DELAY) ? MAX_PIPE_DELAY : PIPE_DELAY;

  // Idle pattern of the delayed bus: syncs deasserted, blanked.
  localparam logic                  SYNC_IDLE = ~SYNC_POL;
  localparam logic [SYNC_BUS_W-1:0] BUS_IDLE  = {SYNC_IDLE, SYNC_IDLE, 1'b0};

  // Counter and derived-signal state.
  coord_t r_x;
  coord_t r_y;
  logic   r_display_on;
  logic   r_hsync_raw;
  logic   r_vsync_raw;
  logic   r_line_tick;
  logic   r_vblank_tick;
  logic   r_frame_tick;

  // Next-state values.
  coord_t w_x_next;
  coord_t w_y_next;
  logic   w_x_wrap;
  logic   w_y_wrap;
  logic   w_line_tick;
  logic   w_vblank_tick;
  logic   w_frame_tick;
  logic   w_display_next;
  logic   w_hsync_next;
  logic   w_vsync_next;

  logic [SYNC_BUS_W-1:0] w_raw_bus;
  logic [SYNC_BUS_W-1:0] w_dly_bus;

  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);

  // Counter advance: X every enabled pixel, Y on X wrap, both at frame end.
  // Ticks are only raised on an enabled pixel, so they cannot repeat while
  // pix_en is low.
  always_comb begin
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_line_tick  = 1'b0;
    w_frame_tick = 1'b0;
    if (pix_en) begin
      w_x_next = wrap_inc(r_x, H_LAST);
      if (w_x_wrap) begin
        w_line_tick  = 1'b1;
        w_y_next     = wrap_inc(r_y, V_LAST);
        w_frame_tick = w_y_wrap;
      end
    end
  end

  // Vertical blank starts on the line where Y first reaches V_ACTIVE.
  assign w_vblank_tick = w_line_tick && (w_y_next == V_VIS);

  // Decode from the next coordinates so the registered flags line up with the
  // registered X/Y in the same cycle. Vsync only depends on Y, so it can only
  // change on an X wrap.
  assign w_display_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);
  assign w_hsync_next   = sync_level(in_window(w_x_next, HS_START, HS_END), SYNC_POL);
  assign w_vsync_next   = sync_level(in_window(w_y_next, VS_START, VS_END), SYNC_POL);

  // Counter, decode and tick registers. Decode registers update every clk;
  // with pix_en low the next coordinates equal the current ones, so they hold,
  // and right after reset display_on picks up the (0,0) value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_display_on  <= 1'b0;
      r_hsync_raw   <= SYNC_IDLE;
      r_vsync_raw   <= SYNC_IDLE;
      r_line_tick   <= 1'b0;
      r_vblank_tick <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_display_on  <= w_display_next;
      r_hsync_raw   <= w_hsync_next;
      r_vsync_raw   <= w_vsync_next;
      r_line_tick   <= w_line_tick;
      r_vblank_tick <= w_vblank_tick;
      r_frame_tick  <= w_frame_tick;
    end
  end

  // Raw DAC-side signals travel together through the delay line.
  assign w_raw_bus = {r_hsync_raw, r_vsync_raw, r_display_on};

  sync_delay_line #(
    .DEPTH (DLY_DEPTH),
    .WIDTH (SYNC_BUS_W)
  ) u_sync_delay (
    .clk       (clk),
    .rst       (rst),
    .i_rst_val (BUS_IDLE),
    .i_d       (w_raw_bus),
    .o_q       (w_dly_bus)
  );

  assign X           = r_x;
  assign Y           = r_y;
  assign display_on  = r_display_on;
  assign hsync       = w_dly_bus[BIT_HSYNC];
  assign vsync       = w_dly_bus[BIT_VSYNC];
  assign blank_n     = w_dly_bus[BIT_BLANK];
  assign line_tick   = r_line_tick;
  assign vblank_tick = r_vblank_tick;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three instances (default mode, no delay with
// active-high syncs, and a tiny 7x6 raster) share clk/rst/pix_en. Every clk
// the expected outputs of each instance are pushed to a queue when the inputs
// are driven and popped for comparison 1 ns after the active edge.
module tb_vga_timing_generator;

  localparam int NINST = 3;

  typedef struct {
    int   ha, hfp, hs, hbp;
    int   va, vfp, vs, vbp;
    int   pd;
    logic pol;
  } cfg_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        disp;
    logic        lt;
    logic        vt;
    logic        ft;
    logic [2:0]  dly;   // {hsync, vsync, blank_n} expected at the pins
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  logic [15:0] x_o  [NINST];
  logic [15:0] y_o  [NINST];
  logic        disp_o [NINST];
  logic        hs_o [NINST];
  logic        vs_o [NINST];
  logic        bn_o [NINST];
  logic        lt_o [NINST];
  logic        vt_o [NINST];
  logic        ft_o [NINST];

  exp_t       exp_q [NINST][$];
  logic [2:0] raw_q [NINST][$];
  int         mx [NINST];
  int         my [NINST];

  int errors = 0;
  int checks = 0;
  int cnt_lt [NINST];
  int cnt_vt [NINST];
  int cnt_ft [NINST];
  int cnt_hs1;
  int first_hs_x;

  always #5 clk = ~clk;

  vga_timing_generator u_dut_default (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .X(x_o[0]), .Y(y_o[0]), .display_on(disp_o[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .blank_n(bn_o[0]),
    .line_tick(lt_o[0]), .vblank_tick(vt_o[0]), .frame_tick(ft_o[0])
  );

  vga_timing_generator #(
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) u_dut_nodelay (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .X(x_o[1]), .Y(y_o[1]), .display_on(disp_o[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .blank_n(bn_o[1]),
    .line_tick(lt_o[1]), .vblank_tick(vt_o[1]), .frame_tick(ft_o[1])
  );

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .X(x_o[2]), .Y(y_o[2]), .display_on(disp_o[2]),
    .hsync(hs_o[2]), .vsync(vs_o[2]), .blank_n(bn_o[2]),
    .line_tick(lt_o[2]), .vblank_tick(vt_o[2]), .frame_tick(ft_o[2])
  );

  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    c.ha = 640; c.hfp = 16; c.hs = 96; c.hbp = 48;
    c.va = 480; c.vfp = 10; c.vs = 2;  c.vbp = 33;
    c.pd = 2;   c.pol = 1'b0;
    if (i == 1) begin
      c.pd  = 0;
      c.pol = 1'b1;
    end else if (i == 2) begin
      c.ha = 4; c.hfp = 1; c.hs = 1; c.hbp = 1;
      c.va = 3; c.vfp = 1; c.vs = 1; c.vbp = 1;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t observed=%0h expected=%0h", tag, inst, $time, obs, expv);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NINST; i++) begin
      cnt_lt[i] = 0;
      cnt_vt[i] = 0;
      cnt_ft[i] = 0;
    end
    cnt_hs1    = 0;
    first_hs_x = -1;
  endtask

  // One clk: drive inputs, push the model's expectation, then compare.
  task automatic step(input logic rst_v, input logic en_v);
    cfg_t       c;
    exp_t       e;
    logic       hr;
    logic       vr;
    logic [2:0] idle;
    int         ht;
    int         vtot;
    rst    = rst_v;
    pix_en = en_v;
    for (int i = 0; i < NINST; i++) begin
      c    = get_cfg(i);
      ht   = c.ha + c.hfp + c.hs + c.hbp;
      vtot = c.va + c.vfp + c.vs + c.vbp;
      idle = {~c.pol, ~c.pol, 1'b0};
      e    = '0;
      if (!rst_v) begin
        mx[i] = 0;
        my[i] = 0;
        raw_q[i].delete();
        for (int k = 0; k < c.pd; k++) raw_q[i].push_back(idle);
        e.dly = idle;
      end else begin
        if (en_v) begin
          if (mx[i] == ht - 1) begin
            mx[i] = 0;
            e.lt  = 1'b1;
            if (my[i] == vtot - 1) begin
              my[i] = 0;
              e.ft  = 1'b1;
            end else begin
              my[i] = my[i] + 1;
              e.vt  = (my[i] == c.va);
            end
          end else begin
            mx[i] = mx[i] + 1;
          end
        end
        e.disp = (mx[i] < c.ha) && (my[i] < c.va);
        hr = (mx[i] >= c.ha + c.hfp && mx[i] < c.ha + c.hfp + c.hs) ? c.pol : ~c.pol;
        vr = (my[i] >= c.va + c.vfp && my[i] < c.va + c.vfp + c.vs) ? c.pol : ~c.pol;
        raw_q[i].push_back({hr, vr, e.disp});
        e.dly = raw_q[i].pop_front();
      end
      e.x = 16'(mx[i]);
      e.y = 16'(my[i]);
      exp_q[i].push_back(e);
    end

    @(posedge clk);
    #1;

    for (int i = 0; i < NINST; i++) begin
      e = exp_q[i].pop_front();
      chk("X",           i, 32'(x_o[i]),   32'(e.x));
      chk("Y",           i, 32'(y_o[i]),   32'(e.y));
      chk("display_on",  i, 32'(disp_o[i]), 32'(e.disp));
      chk("line_tick",   i, 32'(lt_o[i]),  32'(e.lt));
      chk("vblank_tick", i, 32'(vt_o[i]),  32'(e.vt));
      chk("frame_tick",  i, 32'(ft_o[i]),  32'(e.ft));
      chk("hsync",       i, 32'(hs_o[i]),  32'(e.dly[2]));
      chk("vsync",       i, 32'(vs_o[i]),  32'(e.dly[1]));
      chk("blank_n",     i, 32'(bn_o[i]),  32'(e.dly[0]));
      if (lt_o[i] === 1'b1) cnt_lt[i]++;
      if (vt_o[i] === 1'b1) cnt_vt[i]++;
      if (ft_o[i] === 1'b1) cnt_ft[i]++;
    end
    if (hs_o[1] === 1'b1) begin
      cnt_hs1++;
      if (first_hs_x < 0) first_hs_x = int'(x_o[1]);
    end
  endtask

  initial begin
    rst    = 1'b0;
    pix_en = 1'b0;
    clear_counts();

    $display("step 1: reset held for 3 clk");
    repeat (3) step(1'b0, 1'b0);
    chk("rst_hsync_idle_low_pol", 0, 32'(hs_o[0]), 32'(1));
    chk("rst_hsync_idle_high_pol", 1, 32'(hs_o[1]), 32'(0));
    chk("rst_blank_n", 0, 32'(bn_o[0]), 32'(0));

    $display("step 2: release reset, pix_en idle for 2 clk");
    step(1'b1, 1'b0);
    chk("disp_after_release", 0, 32'(disp_o[0]), 32'(1));
    step(1'b1, 1'b0);

    $display("step 3: one full line of 800 back-to-back pixels");
    clear_counts();
    repeat (800) step(1'b1, 1'b1);
    chk("line_tick_count", 0, 32'(cnt_lt[0]), 32'(1));
    chk("X_after_line", 0, 32'(x_o[0]), 32'(0));
    chk("Y_after_line", 0, 32'(y_o[0]), 32'(1));
    chk("hsync_high_cycles", 1, 32'(cnt_hs1), 32'(96));
    chk("hsync_first_x", 1, 32'(first_hs_x), 32'(656));

    $display("step 4: pix_en every second clk for 200 pixels");
    repeat (200) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    chk("X_half_rate", 0, 32'(x_o[0]), 32'(200));

    $display("step 5: advance to X=300 and pulse reset mid-line");
    repeat (100) step(1'b1, 1'b1);
    chk("X_before_reset", 0, 32'(x_o[0]), 32'(300));
    step(1'b0, 1'b1);
    chk("mid_rst_X", 0, 32'(x_o[0]), 32'(0));
    chk("mid_rst_Y", 0, 32'(y_o[0]), 32'(0));
    chk("mid_rst_blank_n", 0, 32'(bn_o[0]), 32'(0));
    chk("mid_rst_hsync", 0, 32'(hs_o[0]), 32'(1));
    chk("mid_rst_vsync", 0, 32'(vs_o[0]), 32'(1));
    step(1'b1, 1'b0);

    $display("step 6: one full 7x6 frame on the small raster");
    clear_counts();
    repeat (42) step(1'b1, 1'b1);
    chk("small_frame_ticks", 2, 32'(cnt_ft[2]), 32'(1));
    chk("small_line_ticks", 2, 32'(cnt_lt[2]), 32'(6));
    chk("small_vblank_ticks", 2, 32'(cnt_vt[2]), 32'(1));
    chk("small_X_wrapped", 2, 32'(x_o[2]), 32'(0));
    chk("small_Y_wrapped", 2, 32'(y_o[2]), 32'(0));

    $display("step 7: random pix_en for 1500 clk");
    repeat (1500) step(1'b1, 1'($urandom_range(0, 1)));

    $display("step 8: continuous pix_en for 1200 clk");
    repeat (1200) step(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
